comparator_pipe: RTL
====================

// Module: comparator_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 16-bit combinational comparator.
//  - Compares data1 against r15 in signed or unsigned mode; issues lt/gt/equal.
//  - Fixed latency of STAGES cycles; valid/ready handshake on both sides.
//  - Sits between the register-read stage and the branch/flag logic of the core.
// PARAMETERS
//  WIDTH   16  operand width in bits (>=2)
//  STAGES  2   pipeline depth, i.e. accept-to-result latency in cycles; legal range 1..4
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  in_valid     in   1      operand pair presented
//  in_ready     out  1      block can accept this cycle
//  data1        in   WIDTH  operand A
//  r15          in   WIDTH  operand B
//  signed_mode  in   1      1: two's-complement compare, 0: unsigned compare
//  out_valid    out  1      result present at output
//  out_ready    in   1      consumer takes result this cycle
//  lt           out  1      A < B
//  gt           out  1      A > B
//  equal        out  1      A == B
//  min_out      out  WIDTH  smaller operand (only with CMP_MINMAX_EN)
//  max_out      out  WIDTH  larger operand (only with CMP_MINMAX_EN)
// BEHAVIOUR
//  - Reset: every stage valid bit = 0. out_valid = 0, lt = gt = equal = 0, min_out = max_out = 0.
//    in_ready = 1 from the first cycle after reset.
//  - advance = !out_valid | out_ready. in_ready = advance (combinational).
//  - Accept occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
//  - On advance, every stage shifts one place and stage 0 loads {in_valid, operands, mode}.
//    When !advance, all stages hold. Bubbles travel with the pipe and are not collapsed.
//  - Latency: an op accepted at edge N is presented with out_valid = 1 after edge N+STAGES-1,
//    provided no stall occurs.
//  - Compare: computed in stage 0 and carried as 3 flag bits.
//    - Unsigned: plain WIDTH-bit magnitude compare.
//    - Signed: MSB sign compare; if signs are equal, magnitude compare of the remaining bits.
//  - Whenever out_valid = 1, exactly one of lt/gt/equal is 1.
//    Whenever out_valid = 0, all three are forced to 0.
//  - Ordering: results leave strictly in acceptance order. None is dropped or duplicated
//    under any out_ready pattern.
//  - Full: when the last stage is valid and out_ready = 0, in_ready = 0 and in_valid is ignored.
//  - Simultaneous accept and output transfer in one cycle is legal, giving 1 op/cycle throughput.
//  - Reset mid-operation: all in-flight ops are discarded on the reset edge.
//    No pre-reset result ever reaches the output.
//  - Operand extremes: 0x8000 vs 0x7FFF (WIDTH = 16) gives lt when signed and gt when unsigned.
// CONFIGURATION
//  - CMP_MINMAX_EN defined:
//    - The pipe also carries both operands.
//    - min_out / max_out are driven from the last stage and valid with out_valid.
//    - On equal, both equal the operand value.
//    - min_out / max_out are 0 when out_valid = 0.
//  - CMP_MINMAX_EN undefined:
//    - Operands are not stored past stage 0.
//    - min_out / max_out ports are absent.
// TESTING (WIDTH=16, STAGES=2 unless noted)
//  1. Hold reset=1 for 2 cycles -> out_valid=0, lt=gt=equal=0, in_ready=1 on release.
//  2. Unsigned, data1=0x000F, r15=0x0007, accepted at edge N
//     -> out_valid=1 after edge N+1, gt=1, lt=0, equal=0.
//  3. data1=0xFFFF, r15=0x0001
//     -> signed_mode=1 gives lt=1; signed_mode=0 gives gt=1. Also check 0x1234 vs 0x1234 -> equal=1.
//  4. out_ready=0 with ops 20vs40, 40vs20, 5vs5 issued back-to-back
//     -> in_ready drops after 2 accepts.
//     -> With out_ready=1, outputs lt, gt, equal appear in order, each exactly once.
//  5. Two ops in flight, then reset=1 for 1 cycle -> out_valid=0 next cycle and no stale result later.
//  6. CMP_MINMAX_EN, STAGES=4, data1=0x0014, r15=0x0028
//     -> after 4 cycles lt=1, min_out=0x0014, max_out=0x0028.

Source files
------------

// File: rtl/comparator_pipe.sv
// -----------------------------------------------------------------------------
// comparator_pipe
//   Pipelined signed/unsigned magnitude comparator with a valid/ready handshake
//   on both sides. The compare runs in stage 0. Its three result flags
//   (lt/gt/equal) then ripple down a STAGES-deep shift pipe. Every stage moves
//   together whenever the output side can advance. Bubbles stay in the pipe.
//
//   Optional feature macro: CMP_MINMAX_EN
//     When this macro is defined, the pipe also carries both operands. It then
//     drives min_out/max_out from the last stage.
//
// Parameters
//   WIDTH   operand width in bits (>= 2)
//   STAGES  accept-to-result latency in cycles (1..4)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     operand pair presented
//   in_ready     block can accept this cycle (combinational)
//   data1        operand A
//   r15          operand B
//   signed_mode  1: two's-complement compare, 0: unsigned compare
//   out_valid    result present at output
//   out_ready    consumer takes result this cycle
//   lt/gt/equal  A < B / A > B / A == B, all forced low without out_valid
//   min_out      smaller operand (CMP_MINMAX_EN only, 0 without out_valid)
//   max_out      larger operand  (CMP_MINMAX_EN only, 0 without out_valid)
// -----------------------------------------------------------------------------
module comparator_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] r15,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
`ifdef CMP_MINMAX_EN
  output logic             equal,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out
`else
  output logic             equal
`endif
);

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } flags_t;

  flags_t            cmp_flags;
  logic              advance;
  logic [STAGES-1:0] valid_q, valid_d;
  flags_t            flags_q [STAGES];
  flags_t            flags_d [STAGES];
`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
`endif

  // Stage-0 compare.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    cmp_flags = '0;
    if (signed_mode && (data1[WIDTH-1] != r15[WIDTH-1])) begin
      // The signs differ, so the negative operand is the smaller one.
      cmp_flags.lt = data1[WIDTH-1];
      cmp_flags.gt = r15[WIDTH-1];
    end else if (signed_mode) begin
      // The signs are equal, so the remaining bits decide.
      cmp_flags.lt = (data1[WIDTH-2:0] <  r15[WIDTH-2:0]);
      cmp_flags.gt = (data1[WIDTH-2:0] >  r15[WIDTH-2:0]);
      cmp_flags.eq = (data1[WIDTH-2:0] == r15[WIDTH-2:0]);
    end else begin
      cmp_flags.lt = (data1 <  r15);
      cmp_flags.gt = (data1 >  r15);
      cmp_flags.eq = (data1 == r15);
    end
  end

  // The whole pipe moves as one unit. It stalls only when a result waits at
  // the output and the consumer is not taking it.
  assign out_valid = valid_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      flags_d[i] = flags_q[i];
`ifdef CMP_MINMAX_EN
      a_d[i] = a_q[i];
      b_d[i] = b_q[i];
`endif
    end
    if (advance) begin
      valid_d[0] = in_valid;
      flags_d[0] = cmp_flags;
`ifdef CMP_MINMAX_EN
      a_d[0] = data1;
      b_d[0] = r15;
`endif
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        flags_d[i] = flags_q[i-1];
`ifdef CMP_MINMAX_EN
        a_d[i] = a_q[i-1];
        b_d[i] = b_q[i-1];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // NOTE: payload flops have no reset. The valid bits qualify them, and the outputs are gated with out_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      flags_q[i] <= flags_d[i];
`ifdef CMP_MINMAX_EN
      a_q[i] <= a_d[i];
      b_q[i] <= b_d[i];
`endif
    end
  end

  assign lt    = out_valid && flags_q[STAGES-1].lt;
  assign gt    = out_valid && flags_q[STAGES-1].gt;
  assign equal = out_valid && flags_q[STAGES-1].eq;

`ifdef CMP_MINMAX_EN
  // When the operands are equal, A and B hold the same value, so either choice is correct.
  assign min_out = !out_valid ? '0 : (flags_q[STAGES-1].lt ? a_q[STAGES-1] : b_q[STAGES-1]);
  assign max_out = !out_valid ? '0 : (flags_q[STAGES-1].lt ? b_q[STAGES-1] : a_q[STAGES-1]);
`endif

endmodule
